// File: rtl/key_event_pkg.sv
// Shared constants, frame layout and frame FSM state type for the key event
// SPI readout path.
package key_event_pkg;

  localparam int FRM_VALID   = 15;
  localparam int FRM_OVF     = 14;
  localparam int FRM_LVL_MSB = 13;
  localparam int FRM_LVL_LSB = 8;

  localparam logic [7:0] EMPTY_CODE = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } frame_state_e;

  // Assemble the 16-bit readout word; the head byte is forced to EMPTY_CODE when nothing is stored.
  function automatic logic [15:0] build_frame(input logic       ovf,
                                              input logic [5:0] level,
                                              input logic [7:0] head);
    logic [15:0] frm;
    frm = 16'h0000;
    frm[FRM_VALID] = (level != 6'd0);
    frm[FRM_OVF] = ovf;
    frm[FRM_LVL_MSB:FRM_LVL_LSB] = level;
    frm[7:0] = (level != 6'd0) ? head : EMPTY_CODE;
    return frm;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous first-word-fall-through FIFO for key event codes. A push on a
// full FIFO is accepted only when a pop happens in the same cycle.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  output logic [7:0]    dout_o,
  output logic [AW:0]   level_o,
  output logic          nonempty_o,
  output logic          full_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          nonempty_q;
  logic          nonempty_d;
  logic          pop_ok_s;
  logic          push_ok_s;

  // Occupancy is judged after a same-cycle pop, so full+pop still accepts the push.
  always_comb begin
    pop_ok_s   = pop_i && (level_q != '0);
    push_ok_s  = push_i && ((level_q != LVL_FULL) || pop_ok_s);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      level_d = level_q + LVL_ONE;
    end else if (pop_ok_s && !push_ok_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end
    nonempty_d = (level_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      nonempty_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      nonempty_q <= nonempty_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o     = nonempty_q ? mem_q[rd_ptr_q] : EMPTY_CODE;
  assign level_o    = level_q;
  assign nonempty_o = nonempty_q;
  assign full_o     = (level_q == LVL_FULL);

endmodule

// File: rtl/key_event_spi_reader.sv
// Key event consumer: captures KEY_CODE_INT events into a FIFO, raises KEY_IRQ
// and serves 16-bit status/event frames to the MCU over an oversampled SPI mode-0 slave.
module key_event_spi_reader
  import key_event_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_LOW,
  input  logic        RST,
  input  logic        KEY_CODE_INT,
  input  logic [7:0]  KEY_CODE_VALUE,
  input  logic        SPI_CS_N,
  input  logic        SPI_SCLK,
  output logic        SPI_MISO,
  output logic        KEY_IRQ,
  output logic [AW:0] FIFO_LEVEL,
  output logic        OVERFLOW
);

  logic                   int_q;
  logic                   push_q;
  logic                   key_edge_s;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic                   cs_prev_q;
  logic                   sclk_prev_q;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  frame_state_e           state_q;
  logic [15:0]            shreg_q;
  logic [4:0]             cnt_q;
  logic                   miso_q;
  logic                   snap_valid_q;
  logic                   snap_ovf_q;
  logic                   ovf_q;
  logic                   ovf_d;
  logic                   pop_s;
  logic                   clr_s;
  logic                   drop_s;
  logic [15:0]            frame_s;
  logic [7:0]             fifo_dout_s;
  logic [AW:0]            fifo_level_s;
  logic                   fifo_nonempty_s;
  logic                   fifo_full_s;

  assign key_edge_s = KEY_CODE_INT && !int_q;

  // The push lags the strobe edge by one cycle so KEY_CODE_VALUE has settled.
  always_ff @(posedge CLK_LOW) begin
    if (RST) begin
      int_q  <= 1'b0;
      push_q <= 1'b0;
    end else begin
      int_q  <= KEY_CODE_INT;
      push_q <= key_edge_s;
    end
  end

  always_ff @(posedge CLK_LOW) begin
    if (RST) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_fall_s   = cs_prev_q && !cs_s;
  assign cs_rise_s   = !cs_prev_q && cs_s;
  assign sclk_rise_s = !sclk_prev_q && sclk_s;
  assign sclk_fall_s = sclk_prev_q && !sclk_s;

  assign frame_s = build_frame(ovf_q, 6'(fifo_level_s), fifo_dout_s);

  // Only a complete frame consumes the head entry or acknowledges the overflow it reported.
  assign pop_s  = (state_q == DONE) && (cnt_q == 5'd16) && snap_valid_q;
  assign clr_s  = (state_q == DONE) && (cnt_q == 5'd16) && snap_ovf_q;
  assign drop_s = push_q && fifo_full_s && !pop_s;

  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge CLK_LOW) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge CLK_LOW) begin
    if (RST) begin
      state_q      <= IDLE;
      shreg_q      <= 16'h0000;
      cnt_q        <= 5'd0;
      miso_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall_s) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          shreg_q      <= frame_s;
          miso_q       <= frame_s[FRM_VALID];
          snap_valid_q <= frame_s[FRM_VALID];
          snap_ovf_q   <= frame_s[FRM_OVF];
          cnt_q        <= 5'd0;
          state_q      <= SHIFT;
        end
        SHIFT: begin
          if (cs_rise_s) begin
            miso_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            if (sclk_rise_s && (cnt_q != 5'd16)) begin
              cnt_q <= cnt_q + 5'd1;
            end
            // Rotate rather than shift so every register bit stays live; the wrapped bits are never read.
            if (sclk_fall_s) begin
              shreg_q <= {shreg_q[14:0], shreg_q[15]};
              miso_q  <= shreg_q[14];
            end
          end
        end
        DONE: begin
          miso_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          miso_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  key_event_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i      (CLK_LOW),
    .rst_i      (RST),
    .push_i     (push_q),
    .din_i      (KEY_CODE_VALUE),
    .pop_i      (pop_s),
    .dout_o     (fifo_dout_s),
    .level_o    (fifo_level_s),
    .nonempty_o (fifo_nonempty_s),
    .full_o     (fifo_full_s)
  );

  assign SPI_MISO   = miso_q;
  assign KEY_IRQ    = fifo_nonempty_s;
  assign FIFO_LEVEL = fifo_level_s;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_key_event_spi_reader.sv
// Self-checking bench for key_event_spi_reader: a queue model of the FIFO,
// a scoreboard of expected frames, a vector table and directed corner sequences.
module tb_key_event_spi_reader;

  localparam int PH = 6;

  logic       clk;
  logic       RST;
  logic       KEY_CODE_INT;
  logic [7:0] KEY_CODE_VALUE;
  logic       SPI_CS_N;
  logic       SPI_SCLK;
  logic       SPI_MISO;
  logic       KEY_IRQ;
  logic [4:0] FIFO_LEVEL;
  logic       OVERFLOW;

  logic [7:0]  mdl_q[$];
  logic        mdl_ovf;
  logic [15:0] sb_q[$];
  int          vec_cnt;
  int          err_cnt;
  logic [15:0] rx;

  typedef struct {
    logic [7:0]  code;
    int          hold;
    logic [15:0] frame;
  } vec_t;

  vec_t vt[4];

  key_event_spi_reader #(.DEPTH(16), .AW(4), .SYNC_STAGES(2)) dut (
    .CLK_LOW        (clk),
    .RST            (RST),
    .KEY_CODE_INT   (KEY_CODE_INT),
    .KEY_CODE_VALUE (KEY_CODE_VALUE),
    .SPI_CS_N       (SPI_CS_N),
    .SPI_SCLK       (SPI_SCLK),
    .SPI_MISO       (SPI_MISO),
    .KEY_IRQ        (KEY_IRQ),
    .FIFO_LEVEL     (FIFO_LEVEL),
    .OVERFLOW       (OVERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_frame();
    logic [15:0] f;
    int n;
    n = mdl_q.size();
    f = 16'h0000;
    f[15] = (n != 0);
    f[14] = mdl_ovf;
    f[13:8] = 6'(n);
    f[7:0] = (n != 0) ? mdl_q[0] : 8'h00;
    return f;
  endfunction

  function automatic void model_push(input logic [7:0] code);
    if (mdl_q.size() < 16) mdl_q.push_back(code);
    else mdl_ovf = 1'b1;
  endfunction

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_level"}, 32'(FIFO_LEVEL), mdl_q.size());
    check({tag, "_irq"}, 32'(KEY_IRQ), 32'(mdl_q.size() != 0));
    check({tag, "_ovf"}, 32'(OVERFLOW), 32'(mdl_ovf));
    check({tag, "_miso_idle"}, 32'(SPI_MISO), 32'd0);
  endtask

  // Strobe high for 'hold' cycles; the code is driven from the cycle after the edge.
  task automatic send_event(input logic [7:0] code, input int hold, input bit chk);
    int lvl0;
    int last;
    lvl0 = mdl_q.size();
    last = (hold < 2) ? 2 : hold;
    @(posedge clk); #1;
    KEY_CODE_INT = 1'b1;
    KEY_CODE_VALUE = 8'hEE;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (c == 1) KEY_CODE_VALUE = code;
      if (c == hold) KEY_CODE_INT = 1'b0;
      if (chk) begin
        @(negedge clk);
        if (c == 1) check("level_at_n1", 32'(FIFO_LEVEL), lvl0);
        if (c == 2) begin
          check("level_at_n2", 32'(FIFO_LEVEL), lvl0 + 1);
          check("irq_at_n2", 32'(KEY_IRQ), 32'd1);
        end
      end
    end
    KEY_CODE_INT = 1'b0;
    model_push(code);
  endtask

  // One SPI transaction of 'nrises' SCLK rises; optional reset mid-frame or an event timed into DONE.
  task automatic spi_frame(input int nrises, input bit rst_mid, input bit inject,
                           input logic [7:0] inj_code, output logic [15:0] data);
    logic [15:0] exp;
    bit          snap_ovf;
    exp = exp_frame();
    sb_q.push_back(exp);
    snap_ovf = mdl_ovf;
    data = 16'h0000;
    @(posedge clk); #1;
    SPI_CS_N = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < nrises; i++) begin
      @(negedge clk);
      data = {data[14:0], SPI_MISO};
      @(posedge clk); #1;
      SPI_SCLK = 1'b1;
      repeat (PH) @(posedge clk);
      if (!(rst_mid && i == nrises - 1)) begin
        #1;
        SPI_SCLK = 1'b0;
        repeat (PH) @(posedge clk);
      end
    end
    if (rst_mid) begin
      #1;
      RST = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_miso", 32'(SPI_MISO), 32'd0);
      check("rst_mid_irq", 32'(KEY_IRQ), 32'd0);
      check("rst_mid_level", 32'(FIFO_LEVEL), 32'd0);
      check("rst_mid_ovf", 32'(OVERFLOW), 32'd0);
      SPI_SCLK = 1'b0;
      SPI_CS_N = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      RST = 1'b0;
      void'(sb_q.pop_front());
      mdl_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      #1;
      SPI_CS_N = 1'b1;
      if (inject) begin
        @(posedge clk);
        @(posedge clk); #1;
        KEY_CODE_INT = 1'b1;
        KEY_CODE_VALUE = 8'hEE;
        @(posedge clk); #1;
        KEY_CODE_VALUE = inj_code;
        KEY_CODE_INT = 1'b0;
      end
      repeat (8) @(posedge clk);
      exp = sb_q.pop_front();
      if (nrises == 16) begin
        check("sb_frame", 32'(data), 32'(exp));
        if (exp[15]) void'(mdl_q.pop_front());
        if (snap_ovf) mdl_ovf = 1'b0;
      end else begin
        check("sb_partial", 32'(data), 32'(exp >> (16 - nrises)));
      end
      if (inject) model_push(inj_code);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    mdl_ovf = 1'b0;
    RST = 1'b1;
    KEY_CODE_INT = 1'b0;
    KEY_CODE_VALUE = 8'h00;
    SPI_CS_N = 1'b1;
    SPI_SCLK = 1'b0;

    vt[0] = '{code: 8'h85, hold: 3, frame: 16'h8185};
    vt[1] = '{code: 8'h5A, hold: 1, frame: 16'h815A};
    vt[2] = '{code: 8'hFF, hold: 5, frame: 16'h81FF};
    vt[3] = '{code: 8'h00, hold: 2, frame: 16'h8100};

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_miso", 32'(SPI_MISO), 32'd0);
    check("reset_irq", 32'(KEY_IRQ), 32'd0);
    check("reset_level", 32'(FIFO_LEVEL), 32'd0);
    check("reset_ovf", 32'(OVERFLOW), 32'd0);
    @(posedge clk); #1;
    RST = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      send_event(vt[i].code, vt[i].hold, 1'b1);
      check_state("tbl_before");
      spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
      check("tbl_frame", 32'(rx), 32'(vt[i].frame));
      check_state("tbl_after");
    end

    for (int c = 1; c <= 17; c++) send_event(8'(c), 1, 1'b0);
    check_state("full");
    check("full_level", 32'(FIFO_LEVEL), 32'd16);
    check("full_ovf", 32'(OVERFLOW), 32'd1);
    spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
    check("ovf_frame1", 32'(rx), 32'hD001);
    check_state("ovf_cleared");
    spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
    check("ovf_frame2", 32'(rx), 32'h8F02);
    while (mdl_q.size() != 0) spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
    check_state("drained");

    spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
    check("empty_frame", 32'(rx), 32'h0000);
    check_state("empty");

    send_event(8'hA1, 1, 1'b0);
    send_event(8'hA2, 2, 1'b0);
    send_event(8'hA3, 1, 1'b0);
    spi_frame(9, 1'b0, 1'b0, 8'h00, rx);
    check("partial_level", 32'(FIFO_LEVEL), 32'd3);
    check_state("partial");
    spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
    check("after_partial_frame", 32'(rx), 32'h83A1);
    while (mdl_q.size() != 0) spi_frame(16, 1'b0, 1'b0, 8'h00, rx);

    send_event(8'hB1, 1, 1'b0);
    send_event(8'hB2, 1, 1'b0);
    spi_frame(16, 1'b0, 1'b1, 8'hB3, rx);
    check("collide_frame", 32'(rx), 32'h82B1);
    check("collide_level", 32'(FIFO_LEVEL), 32'd2);
    check_state("collide");
    for (int k = 0; k < 20; k++) begin
      if ((mdl_q.size() == 0) || (mdl_q.size() < 12 && $urandom_range(0, 1) == 1))
        send_event(8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'b0);
      else
        spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
      check_state("mixed");
    end
    while (mdl_q.size() != 0) spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
    check_state("mixed_drained");

    for (int c = 0; c < 4; c++) send_event(8'hC0 + 8'(c), 1, 1'b0);
    check("pre_rst_level", 32'(FIFO_LEVEL), 32'd4);
    spi_frame(8, 1'b1, 1'b0, 8'h00, rx);
    check_state("post_rst");
    spi_frame(16, 1'b0, 1'b0, 8'h00, rx);
    check("post_rst_frame", 32'(rx), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
